// File: rtl/cim_macro_acc.sv
// Clocked CIM macro: N_PE x N_ROW unsigned weight array with STDW/STDR access,
// per-beat dot products, and a two-register pipeline that accumulates groups of beats.
module cim_macro_acc #(
   parameter int N_PE     = 8,
   parameter int N_ROW    = 64,
   parameter int W_BITS   = 4,
   parameter int A_BITS   = 4,
   parameter int ACC_BITS = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       STDW,
   input  logic                       STDR,
   input  logic [$clog2(N_ROW)-1:0]   STD_A,
   input  logic [N_PE*W_BITS-1:0]     weight_in,
   output logic [N_PE*W_BITS-1:0]     weight_out,
   input  logic                       IN_valid,
   output logic                       IN_ready,
   input  logic                       IN_last,
   input  logic [N_ROW*A_BITS-1:0]    act_in,
   output logic                       OUT_valid,
   input  logic                       OUT_ready,
   output logic [N_PE*ACC_BITS-1:0]   PSUM,
   output logic [N_PE-1:0]            OVF
);

   localparam int ROW_AW   = $clog2(N_ROW);
   localparam int DOT_BITS = W_BITS + A_BITS + ROW_AW;

   // Handshake: a transfer happens on an edge where valid & ready are both high;
   // valid and its payload must hold until then, and ready may depend on the far side.

   logic [N_PE*W_BITS-1:0]  r_mem [N_ROW];
   logic [N_PE*W_BITS-1:0]  r_weight_out;

   logic                    r_s1_valid;
   logic                    r_s1_last;
   logic [DOT_BITS-1:0]     r_s1_psum [N_PE];

   logic                    r_start;
   logic [ACC_BITS-1:0]     r_acc [N_PE];
   logic [N_PE-1:0]         r_ovf;

   logic                    r_out_valid;
   logic [N_PE*ACC_BITS-1:0] r_psum;
   logic [N_PE-1:0]         r_ovf_out;

   logic [DOT_BITS-1:0]     w_dot [N_PE];
   logic [ACC_BITS:0]       w_sum [N_PE];
   logic [ACC_BITS-1:0]     w_acc_nxt [N_PE];
   logic [N_PE-1:0]         w_ovf_nxt;
   logic                    w_s1_adv;
   logic                    w_accept;

   assign w_s1_adv   = r_s1_valid & (~r_out_valid | OUT_ready);
   assign IN_ready   = ~r_s1_valid | w_s1_adv;
   assign w_accept   = IN_valid & IN_ready;

   assign weight_out = r_weight_out;
   assign OUT_valid  = r_out_valid;
   assign PSUM       = r_psum;
   assign OVF        = r_ovf_out;

   // Dot products see the array as it stood before the edge, so a same-cycle STDW
   // only affects later beats.
   always_comb begin
      for (int i = 0; i < N_PE; i++) begin
         w_dot[i] = '0;
         for (int r = 0; r < N_ROW; r++) begin
            w_dot[i] = w_dot[i] + DOT_BITS'(r_mem[r][W_BITS*i +: W_BITS])
                                * DOT_BITS'(act_in[A_BITS*r +: A_BITS]);
         end
      end
   end

   // One extra sum bit flags a clip; the group-start flag zeroes both base and ovf.
   always_comb begin
      for (int i = 0; i < N_PE; i++) begin
         w_sum[i]     = (r_start ? '0 : {1'b0, r_acc[i]}) + (ACC_BITS+1)'(r_s1_psum[i]);
         w_acc_nxt[i] = w_sum[i][ACC_BITS] ? '1 : w_sum[i][ACC_BITS-1:0];
         w_ovf_nxt[i] = (~r_start & r_ovf[i]) | w_sum[i][ACC_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < N_ROW; r++) r_mem[r] <= '0;
         r_weight_out <= '0;
      end else begin
         if (STDR) r_weight_out <= r_mem[STD_A];
         if (STDW) r_mem[STD_A] <= weight_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         for (int i = 0; i < N_PE; i++) r_s1_psum[i] <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_last  <= IN_last;
         for (int i = 0; i < N_PE; i++) r_s1_psum[i] <= w_dot[i];
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_start     <= 1'b1;
         r_ovf       <= '0;
         r_out_valid <= 1'b0;
         r_psum      <= '0;
         r_ovf_out   <= '0;
         for (int i = 0; i < N_PE; i++) r_acc[i] <= '0;
      end else begin
         if (w_s1_adv) begin
            r_ovf <= w_ovf_nxt;
            for (int i = 0; i < N_PE; i++) r_acc[i] <= w_acc_nxt[i];
            if (r_s1_last) begin
               for (int i = 0; i < N_PE; i++) r_psum[ACC_BITS*i +: ACC_BITS] <= w_acc_nxt[i];
               r_ovf_out <= w_ovf_nxt;
               r_start   <= 1'b1;
            end else begin
               r_start   <= 1'b0;
            end
         end
         if (w_s1_adv && r_s1_last) r_out_valid <= 1'b1;
         else if (OUT_ready)        r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cim_macro_acc.sv
// Directed bench for cim_macro_acc: a default-width instance and a 14-bit
// accumulator instance share all stimulus so saturation can be observed.
module tb_cim_macro_acc;

   localparam int N_PE = 8;
   localparam int N_ROW = 64;
   localparam int PW  = N_PE * 20;
   localparam int PW14 = N_PE * 14;

   logic clk, rst_n, STDW, STDR, IN_valid, IN_last, OUT_ready;
   logic [5:0]   STD_A;
   logic [31:0]  weight_in;
   logic [255:0] act_in;

   logic [31:0]   weight_out, sat_weight_out;
   logic          IN_ready, sat_in_ready, OUT_valid, sat_out_valid;
   logic [PW-1:0] PSUM;
   logic [PW14-1:0] sat_psum;
   logic [7:0]    OVF, sat_ovf;

   int n_vec = 0;
   int n_err = 0;
   logic [PW-1:0] exp_q[$];

   cim_macro_acc u_dut (
      .clk(clk), .rst_n(rst_n), .STDW(STDW), .STDR(STDR), .STD_A(STD_A),
      .weight_in(weight_in), .weight_out(weight_out), .IN_valid(IN_valid),
      .IN_ready(IN_ready), .IN_last(IN_last), .act_in(act_in), .OUT_valid(OUT_valid),
      .OUT_ready(OUT_ready), .PSUM(PSUM), .OVF(OVF)
   );

   cim_macro_acc #(.ACC_BITS(14)) u_sat (
      .clk(clk), .rst_n(rst_n), .STDW(STDW), .STDR(STDR), .STD_A(STD_A),
      .weight_in(weight_in), .weight_out(sat_weight_out), .IN_valid(IN_valid),
      .IN_ready(sat_in_ready), .IN_last(IN_last), .act_in(act_in), .OUT_valid(sat_out_valid),
      .OUT_ready(OUT_ready), .PSUM(sat_psum), .OVF(sat_ovf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] rep_psum(input int v);
      logic [PW-1:0] p;
      for (int i = 0; i < N_PE; i++) p[20*i +: 20] = 20'(v);
      return p;
   endfunction

   function automatic logic [PW14-1:0] rep_psum14(input int v);
      logic [PW14-1:0] p;
      for (int i = 0; i < N_PE; i++) p[14*i +: 14] = 14'(v);
      return p;
   endfunction

   function automatic logic [255:0] rep_act(input logic [3:0] v);
      logic [255:0] a;
      for (int r = 0; r < N_ROW; r++) a[4*r +: 4] = v;
      return a;
   endfunction

   // driver tasks
   task automatic write_row(input int r, input logic [31:0] d);
      STDW = 1'b1; STD_A = 6'(r); weight_in = d;
      tick;
      STDW = 1'b0;
   endtask

   task automatic load_ramp;
      logic [31:0] d;
      for (int r = 0; r < N_ROW; r++) begin
         for (int i = 0; i < N_PE; i++) d[4*i +: 4] = 4'((i + r) % 16);
         write_row(r, d);
      end
   endtask

   task automatic load_all(input logic [31:0] d);
      for (int r = 0; r < N_ROW; r++) write_row(r, d);
   endtask

   task automatic send_beat(input logic [255:0] a, input logic last);
      IN_valid = 1'b1; IN_last = last; act_in = a;
      tick;
      IN_valid = 1'b0; IN_last = 1'b0;
   endtask

   task automatic wait_out(output bit got);
      int c;
      got = 1'b0;
      c = 0;
      while (!got && c < 20) begin
         if (OUT_valid) got = 1'b1;
         else begin tick; c++; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; STDW = 0; STDR = 0; STD_A = 0; weight_in = 0;
      IN_valid = 0; IN_last = 0; act_in = 0; OUT_ready = 1;
      tick; tick;
      n_vec++; if (weight_out !== 32'h0) begin n_err++; $display("FAIL rst_weight_out: got %0h want 0", weight_out); end
      n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", OUT_valid); end
      n_vec++; if (PSUM !== '0) begin n_err++; $display("FAIL rst_psum: got %0h want 0", PSUM); end
      n_vec++; if (OVF !== 8'h0) begin n_err++; $display("FAIL rst_ovf: got %0h want 0", OVF); end
      rst_n = 1'b1;
      tick;
      n_vec++; if (IN_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", IN_ready); end
   endtask

   task automatic test_write_read;
      for (int r = 0; r < N_ROW; r++) write_row(r, 32'h76543210 ^ 32'(r));
      for (int r = 0; r < N_ROW; r++) begin
         STDR = 1'b1; STD_A = 6'(r);
         tick;
         n_vec++;
         if (weight_out !== (32'h76543210 ^ 32'(r))) begin
            n_err++; $display("FAIL read_row%0d: got %h want %h", r, weight_out, 32'h76543210 ^ 32'(r));
         end
      end
      STDW = 1'b1; STDR = 1'b1; STD_A = 6'd5; weight_in = 32'hDEADBEEF;
      tick;
      STDW = 1'b0;
      n_vec++; if (weight_out !== 32'h76543215) begin n_err++; $display("FAIL rw_same_row: got %h want 76543215", weight_out); end
      tick;
      STDR = 1'b0;
      n_vec++; if (weight_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_after_write: got %h want deadbeef", weight_out); end
      tick;
      n_vec++; if (weight_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_hold: got %h want deadbeef", weight_out); end
   endtask

   task automatic test_single_max;
      load_all(32'hFFFFFFFF);
      OUT_ready = 1'b1;
      IN_valid = 1'b1; IN_last = 1'b1; act_in = rep_act(4'hF);
      #1;
      n_vec++; if (IN_ready !== 1'b1) begin n_err++; $display("FAIL max_in_ready: got %b want 1", IN_ready); end
      tick;
      IN_valid = 1'b0; IN_last = 1'b0;
      n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL max_latency_early: got %b want 0", OUT_valid); end
      tick;
      n_vec++; if (OUT_valid !== 1'b1) begin n_err++; $display("FAIL max_latency: got %b want 1", OUT_valid); end
      n_vec++; if (PSUM !== rep_psum(14400)) begin n_err++; $display("FAIL max_psum: got %h want %h", PSUM, rep_psum(14400)); end
      n_vec++; if (OVF !== 8'h00) begin n_err++; $display("FAIL max_ovf: got %h want 00", OVF); end
      n_vec++; if (sat_psum !== rep_psum14(14400)) begin n_err++; $display("FAIL max_psum14: got %h want %h", sat_psum, rep_psum14(14400)); end
      tick;
      n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL max_consumed: got %b want 0", OUT_valid); end
   endtask

   task automatic test_multi_tile;
      bit got;
      logic [PW-1:0] e;
      logic [255:0] a;
      int s;
      load_ramp;
      for (int b = 0; b < 4; b++) begin
         send_beat(rep_act(4'h1), b == 3);
         n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL multi_early_b%0d: got %b want 0", b, OUT_valid); end
      end
      wait_out(got);
      n_vec++; if (!got) begin n_err++; $display("FAIL multi_timeout: got no OUT_valid want 1"); end
      n_vec++; if (PSUM !== rep_psum(1920)) begin n_err++; $display("FAIL multi_psum: got %h want %h", PSUM, rep_psum(1920)); end
      n_vec++; if (OVF !== 8'h00) begin n_err++; $display("FAIL multi_ovf: got %h want 00", OVF); end
      tick;
      n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL multi_once: got %b want 0", OUT_valid); end
      // non-uniform activations make each PE distinct
      for (int r = 0; r < N_ROW; r++) a[4*r +: 4] = 4'(r % 16);
      for (int i = 0; i < N_PE; i++) begin
         s = 0;
         for (int r = 0; r < N_ROW; r++) s += ((i + r) % 16) * (r % 16);
         e[20*i +: 20] = 20'(s);
      end
      send_beat(a, 1'b1);
      wait_out(got);
      n_vec++; if (!got || PSUM !== e) begin n_err++; $display("FAIL ramp_psum: got %h want %h", PSUM, e); end
      tick;
      // idle cycles inside a group
      send_beat(rep_act(4'h1), 1'b0);
      tick; tick;
      send_beat(rep_act(4'h1), 1'b1);
      wait_out(got);
      n_vec++; if (!got || PSUM !== rep_psum(960)) begin n_err++; $display("FAIL gap_psum: got %h want %h", PSUM, rep_psum(960)); end
      tick;
   endtask

   task automatic test_saturation;
      bit got;
      load_all(32'hFFFFFFFF);
      send_beat(rep_act(4'hF), 1'b0);
      send_beat(rep_act(4'hF), 1'b1);
      wait_out(got);
      n_vec++; if (!got) begin n_err++; $display("FAIL sat_timeout: got no OUT_valid want 1"); end
      n_vec++; if (sat_psum !== rep_psum14(16383)) begin n_err++; $display("FAIL sat_psum: got %h want %h", sat_psum, rep_psum14(16383)); end
      n_vec++; if (sat_ovf !== 8'hFF) begin n_err++; $display("FAIL sat_ovf: got %h want ff", sat_ovf); end
      n_vec++; if (PSUM !== rep_psum(28800)) begin n_err++; $display("FAIL wide_psum: got %h want %h", PSUM, rep_psum(28800)); end
      n_vec++; if (OVF !== 8'h00) begin n_err++; $display("FAIL wide_ovf: got %h want 00", OVF); end
      tick;
      send_beat(rep_act(4'hF), 1'b1);
      wait_out(got);
      n_vec++; if (!got || sat_psum !== rep_psum14(14400)) begin n_err++; $display("FAIL sat_next_psum: got %h want %h", sat_psum, rep_psum14(14400)); end
      n_vec++; if (sat_ovf !== 8'h00) begin n_err++; $display("FAIL sat_next_ovf: got %h want 00", sat_ovf); end
      tick;
   endtask

   task automatic test_backpressure;
      int sent, got;
      logic [PW-1:0] e;
      load_ramp;
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         OUT_ready = (cyc >= 8);
         IN_valid = (sent < 5); IN_last = 1'b1; act_in = rep_act(4'(sent + 1));
         #1;
         if (cyc == 3 || cyc == 7) begin
            n_vec++; if (IN_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, IN_ready); end
            n_vec++; if (OUT_valid !== 1'b1 || PSUM !== rep_psum(480)) begin
               n_err++; $display("FAIL bp_hold_c%0d: got v=%b %h want v=1 %h", cyc, OUT_valid, PSUM, rep_psum(480));
            end
         end
         if (OUT_valid && OUT_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL bp_extra: got %h want nothing", PSUM);
            end else begin
               e = exp_q.pop_front();
               if (PSUM !== e) begin n_err++; $display("FAIL bp_order%0d: got %h want %h", got, PSUM, e); end
            end
            got++;
         end
         if (IN_valid && IN_ready) begin
            exp_q.push_back(rep_psum(480 * (sent + 1)));
            sent++;
         end
         @(posedge clk); #1;
      end
      IN_valid = 1'b0; IN_last = 1'b0; OUT_ready = 1'b1;
      n_vec++; if (got != 5 || exp_q.size() != 0) begin n_err++; $display("FAIL bp_count: got %0d delivered want 5", got); end
      tick;
      n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", OUT_valid); end
   endtask

   task automatic test_hazard_reset;
      bit got;
      logic [255:0] a;
      logic [PW-1:0] e;
      a = '0; a[3:0] = 4'h1;
      for (int i = 0; i < N_PE; i++) e[20*i +: 20] = 20'(i);
      STDW = 1'b1; STD_A = 6'd0; weight_in = 32'hFFFFFFFF;
      send_beat(a, 1'b1);
      STDW = 1'b0;
      wait_out(got);
      n_vec++; if (!got || PSUM !== e) begin n_err++; $display("FAIL hazard_old: got %h want %h", PSUM, e); end
      tick;
      send_beat(a, 1'b1);
      wait_out(got);
      n_vec++; if (!got || PSUM !== rep_psum(15)) begin n_err++; $display("FAIL hazard_new: got %h want %h", PSUM, rep_psum(15)); end
      tick;
      send_beat(a, 1'b0);
      tick;
      rst_n = 1'b0;
      tick;
      n_vec++; if (OUT_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", OUT_valid); end
      n_vec++; if (PSUM !== '0) begin n_err++; $display("FAIL midrst_psum: got %h want 0", PSUM); end
      rst_n = 1'b1;
      tick;
      write_row(0, 32'h76543210);
      send_beat(a, 1'b1);
      wait_out(got);
      n_vec++; if (!got || PSUM !== e) begin n_err++; $display("FAIL post_rst_psum: got %h want %h", PSUM, e); end
      n_vec++; if (OVF !== 8'h00) begin n_err++; $display("FAIL post_rst_ovf: got %h want 00", OVF); end
      tick;
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_single_max;
      test_multi_tile;
      test_saturation;
      test_backpressure;
      test_hazard_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
